// File: rtl/jt51_wrq_pkg.sv
// Shared types for the jt51 host write queue: FSM encoding, a0 levels and the
// 16-bit FIFO entry layout {addr[15:8], data[7:0]}.
package jt51_wrq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_GRD_A  = 3'd2,
      ST_WAIT_A = 3'd3,
      ST_DATA   = 3'd4,
      ST_GRD_D  = 3'd5,
      ST_WAIT_D = 3'd6
   } wrq_state_t;

   localparam logic YM_A0_ADDR = 1'b0;
   localparam logic YM_A0_DATA = 1'b1;

   localparam int WRQ_ENTRY_W = 16;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wrq_entry_t;

endpackage

// File: rtl/jt51_wrq_fifo.sv
// Single-clock FIFO with extra-bit pointers, occupancy count and a sticky
// overflow flag for pushes dropped while full.
module jt51_wrq_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      wdata_i,
   input  logic                  pop_i,
   output logic [WIDTH-1:0]      rdata_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic                  overflow_o
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
   logic                ovf_q, ovf_d;
   logic                push_ok, pop_ok;

   // Same index with differing wrap bits means the write side lapped the read side.
   assign full_o     = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                       (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign level_o    = wr_ptr_q - rd_ptr_q;
   assign overflow_o = ovf_q;
   assign rdata_o    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q | (push_i & full_o);
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/jt51_wrqueue.sv
// Host register-write queue in front of jt51: buffers (addr, data) pairs and
// replays them as address/data bus writes, honouring the busy flag.
// Optional macro JT51_WRQ_ADDR_CACHE_EN skips the address write when it repeats.
module jt51_wrqueue
   import jt51_wrq_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int GUARD      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [7:0]            push_addr,
   input  logic [7:0]            push_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic                  idle,
   input  logic                  ym_busy,
   output logic                  ym_cs_n,
   output logic                  ym_wr_n,
   output logic                  ym_a0,
   output logic [7:0]            ym_din
);

   localparam int GW = $clog2(GUARD + 1);
   localparam logic [GW-1:0] GRD_LAST = GW'(GUARD - 1);
   localparam logic [GW-1:0] GRD_ONE  = GW'(1);

   wrq_entry_t push_ent, head;
   logic       pop;

   assign push_ent = '{addr: push_addr, data: push_data};

   jt51_wrq_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (WRQ_ENTRY_W)
   ) u_fifo (
      .clk_i      (clk),
      .rst_i      (rst),
      .push_i     (push),
      .wdata_i    (push_ent),
      .pop_i      (pop),
      .rdata_o    (head),
      .full_o     (full),
      .empty_o    (empty),
      .level_o    (level),
      .overflow_o (overflow)
   );

   wrq_state_t    state_q, state_d;
   logic          hold_vld_q, hold_vld_d, hold_load;
   logic [7:0]    haddr_q, hdata_q;
   logic          cs_n_q, cs_n_d, wr_n_q, wr_n_d, a0_q, a0_d;
   logic [7:0]    din_q, din_d;
   logic [GW-1:0] grd_q, grd_d;
   logic          cache_hit;

`ifdef JT51_WRQ_ADDR_CACHE_EN
   logic [7:0] last_addr_q;
   logic       cache_vld_q;

   assign cache_hit = cache_vld_q && (last_addr_q == haddr_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_addr_q <= '0;
         cache_vld_q <= 1'b0;
      end else if (state_q == ST_IDLE && state_d == ST_ADDR) begin
         last_addr_q <= haddr_q;
         cache_vld_q <= 1'b1;
      end
   end
`else
   assign cache_hit = 1'b0;
`endif

   // The pop cycle fills the hold registers; the next edge enters ADDR (or DATA)
   // with the strobe already registered, so outputs change on state entry.
   always_comb begin
      state_d    = state_q;
      hold_vld_d = hold_vld_q;
      hold_load  = 1'b0;
      pop        = 1'b0;
      cs_n_d     = 1'b1;
      wr_n_d     = 1'b1;
      a0_d       = a0_q;
      din_d      = din_q;
      grd_d      = grd_q;
      unique case (state_q)
         ST_IDLE: begin
            if (hold_vld_q) begin
               hold_vld_d = 1'b0;
               cs_n_d     = 1'b0;
               wr_n_d     = 1'b0;
               if (cache_hit) begin
                  state_d = ST_DATA;
                  a0_d    = YM_A0_DATA;
                  din_d   = hdata_q;
               end else begin
                  state_d = ST_ADDR;
                  a0_d    = YM_A0_ADDR;
                  din_d   = haddr_q;
               end
            end else if (!empty) begin
               pop        = 1'b1;
               hold_load  = 1'b1;
               hold_vld_d = 1'b1;
            end
         end
         ST_ADDR: begin
            state_d = ST_GRD_A;
            grd_d   = '0;
         end
         ST_GRD_A: begin
            if (grd_q == GRD_LAST) state_d = ST_WAIT_A;
            else                   grd_d   = grd_q + GRD_ONE;
         end
         ST_WAIT_A: begin
            if (!ym_busy) begin
               state_d = ST_DATA;
               cs_n_d  = 1'b0;
               wr_n_d  = 1'b0;
               a0_d    = YM_A0_DATA;
               din_d   = hdata_q;
            end
         end
         ST_DATA: begin
            state_d = ST_GRD_D;
            grd_d   = '0;
         end
         ST_GRD_D: begin
            if (grd_q == GRD_LAST) state_d = ST_WAIT_D;
            else                   grd_d   = grd_q + GRD_ONE;
         end
         ST_WAIT_D: begin
            if (!ym_busy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         hold_vld_q <= 1'b0;
         cs_n_q     <= 1'b1;
         wr_n_q     <= 1'b1;
         a0_q       <= 1'b0;
         din_q      <= '0;
         grd_q      <= '0;
      end else begin
         state_q    <= state_d;
         hold_vld_q <= hold_vld_d;
         cs_n_q     <= cs_n_d;
         wr_n_q     <= wr_n_d;
         a0_q       <= a0_d;
         din_q      <= din_d;
         grd_q      <= grd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (hold_load) begin
         haddr_q <= head.addr;
         hdata_q <= head.data;
      end
   end

   assign ym_cs_n = cs_n_q;
   assign ym_wr_n = wr_n_q;
   assign ym_a0   = a0_q;
   assign ym_din  = din_q;
   assign idle    = empty && (state_q == ST_IDLE) && !hold_vld_q;

endmodule

// File: tb/tb_jt51_wrqueue.sv
// Scoreboard bench for jt51_wrqueue: expected bus writes are queued as pushes
// are issued, and a monitor checks every strobe against the queue.
module tb_jt51_wrqueue;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       push = 1'b0;
   logic [7:0] push_addr = '0;
   logic [7:0] push_data = '0;
   logic       full, empty, overflow, idle;
   logic [4:0] level;
   logic       ym_busy = 1'b0;
   logic       ym_cs_n, ym_wr_n, ym_a0;
   logic [7:0] ym_din;

   jt51_wrqueue #(.DEPTH_LOG2(4), .GUARD(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_addr (push_addr),
      .push_data (push_data),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .overflow  (overflow),
      .idle      (idle),
      .ym_busy   (ym_busy),
      .ym_cs_n   (ym_cs_n),
      .ym_wr_n   (ym_wr_n),
      .ym_a0     (ym_a0),
      .ym_din    (ym_din)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_vec = 0;
   int         n_miss = 0;
   logic [8:0] exp_q[$];
   int         n_strb = 0;
   int         a_cyc = 0;
   int         d_cyc = 0;
   logic       prev_strb = 1'b0;
   logic       strb;
   logic [8:0] e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: every bus strobe must match the head of the expectation queue.
   always @(negedge clk) begin
      if (rst) begin
         prev_strb = 1'b0;
      end else begin
         strb = !ym_cs_n && !ym_wr_n;
         if (strb) begin
            n_strb++;
            chk("strobe_width", {31'd0, prev_strb}, 32'd0);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_strobe: got a0=%0d din=%0h expected no strobe", ym_a0, ym_din);
            end else begin
               e = exp_q.pop_front();
               chk("bus_a0", {31'd0, ym_a0}, {31'd0, e[8]});
               chk("bus_din", {24'd0, ym_din}, {24'd0, e[7:0]});
            end
            if (ym_a0) d_cyc = cyc;
            else       a_cyc = cyc;
         end
         prev_strb = strb;
      end
   end

   task automatic do_push(input logic [7:0] a, input logic [7:0] d, output int ecyc);
      @(negedge clk);
      push = 1'b1;
      push_addr = a;
      push_data = d;
      @(posedge clk);
      #1;
      ecyc = cyc;
      push = 1'b0;
   endtask

   task automatic wait_strb(input int target);
      int k = 0;
      while (n_strb < target && k < 300) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("strobe_seen", {31'd0, (n_strb >= target)}, 32'd1);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!(idle && exp_q.size() == 0) && k < 2000) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("idle_reached", {31'd0, idle}, 32'd1);
      chk("queue_drained", exp_q.size(), 32'd0);
   endtask

   initial begin
      int n0, n1, pc, fall;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_cs_n", {31'd0, ym_cs_n}, 32'd1);
      chk("rst_wr_n", {31'd0, ym_wr_n}, 32'd1);
      chk("rst_a0", {31'd0, ym_a0}, 32'd0);
      chk("rst_din", {24'd0, ym_din}, 32'd0);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_level", {27'd0, level}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_idle", {31'd0, idle}, 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Single write: address strobe at n+2, data strobe 4 cycles later
      exp_q.push_back({1'b0, 8'h14});
      exp_q.push_back({1'b1, 8'h3A});
      do_push(8'h14, 8'h3A, pc);
      chk("single_idle_low", {31'd0, idle}, 32'd0);
      wait_idle();
      chk("single_addr_cyc", a_cyc, pc + 2);
      chk("single_data_cyc", d_cyc, pc + 6);

      // Busy hold-off after the address strobe
      n0 = n_strb;
      exp_q.push_back({1'b0, 8'h20});
      exp_q.push_back({1'b1, 8'h55});
      do_push(8'h20, 8'h55, pc);
      wait_strb(n0 + 1);
      ym_busy = 1'b1;
      repeat (20) @(negedge clk);
      ym_busy = 1'b0;
      fall = cyc;
      wait_idle();
      chk("busy_data_cyc", d_cyc, fall + 1);

      // Fill while the FSM is stuck in WAIT_A on a blocker entry
      ym_busy = 1'b1;
      n0 = n_strb;
      exp_q.push_back({1'b0, 8'h2F});
      do_push(8'h2F, 8'h9F, pc);
      wait_strb(n0 + 1);
      exp_q.push_back({1'b1, 8'h9F});
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({1'b0, 8'h30 + 8'(i)});
         exp_q.push_back({1'b1, 8'hC0 + 8'(i)});
         do_push(8'h30 + 8'(i), 8'hC0 + 8'(i), pc);
      end
      chk("fill_full16", {31'd0, full}, 32'd1);
      chk("fill_ovf16", {31'd0, overflow}, 32'd0);
      do_push(8'hEE, 8'hEE, pc);
      chk("fill_full", {31'd0, full}, 32'd1);
      chk("fill_level", {27'd0, level}, 32'd16);
      chk("fill_overflow", {31'd0, overflow}, 32'd1);
      ym_busy = 1'b0;
      wait_idle();
      chk("fill_ovf_sticky", {31'd0, overflow}, 32'd1);
      chk("fill_empty", {31'd0, empty}, 32'd1);

      // Reset during WAIT_D with three entries queued
      ym_busy = 1'b1;
      n0 = n_strb;
      exp_q.push_back({1'b0, 8'h40});
      exp_q.push_back({1'b1, 8'h50});
      for (int i = 0; i < 4; i++) do_push(8'h40 + 8'(i), 8'h50 + 8'(i), pc);
      wait_strb(n0 + 1);
      chk("mid_level_a", {27'd0, level}, 32'd3);
      ym_busy = 1'b0;
      wait_strb(n0 + 2);
      ym_busy = 1'b1;
      repeat (5) @(negedge clk);
      chk("mid_level_d", {27'd0, level}, 32'd3);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_cs_n", {31'd0, ym_cs_n}, 32'd1);
      chk("mid_rst_wr_n", {31'd0, ym_wr_n}, 32'd1);
      chk("mid_rst_level", {27'd0, level}, 32'd0);
      chk("mid_rst_idle", {31'd0, idle}, 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ym_busy = 1'b0;
      n1 = n_strb;
      repeat (30) @(negedge clk);
      #1;
      chk("mid_no_strobes", n_strb, n1);
      chk("mid_ovf_cleared", {31'd0, overflow}, 32'd0);
      chk("mid_empty", {31'd0, empty}, 32'd1);

      // Reset asserted in the middle of an address strobe
      n0 = n_strb;
      exp_q.push_back({1'b0, 8'h11});
      do_push(8'h11, 8'h22, pc);
      wait_strb(n0 + 1);
      rst = 1'b1;
      #1;
      chk("async_wr_n", {31'd0, ym_wr_n}, 32'd1);
      chk("async_cs_n", {31'd0, ym_cs_n}, 32'd1);
      chk("async_din", {24'd0, ym_din}, 32'd0);
      chk("async_a0", {31'd0, ym_a0}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n1 = n_strb;
      repeat (20) @(negedge clk);
      #1;
      chk("async_no_strobes", n_strb, n1);

      // Repeated address: cache build skips the second address write
      exp_q.push_back({1'b0, 8'h08});
      exp_q.push_back({1'b1, 8'h01});
`ifndef JT51_WRQ_ADDR_CACHE_EN
      exp_q.push_back({1'b0, 8'h08});
`endif
      exp_q.push_back({1'b1, 8'h02});
      do_push(8'h08, 8'h01, pc);
      do_push(8'h08, 8'h02, pc);
      wait_idle();
      repeat (10) @(negedge clk);
      #1;
      chk("cache_queue_empty", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
